// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: scans a 4x4 active-low key matrix one column at a time,
// collects a full frame of row samples, debounces whole frames and reports each
// new single-key press as a 4-bit code over a valid/ack handshake.
module key_matrix_scanner #(
    parameter int SCAN_COUNT     = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] colDrive,
    input  logic [3:0] rowSense,
    output logic [3:0] keyCode,
    output logic       keyValid,
    input  logic       keyAck,
    output logic       keyPressed,
    output logic       overrun,
    input  logic       clrOverrun
);

    localparam int              SCW       = $clog2(SCAN_COUNT);
    localparam logic [SCW-1:0]  SCAN_LAST = SCW'(SCAN_COUNT - 1);
    localparam int              DBW       = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DBW:0]    DB_TGT    = (DBW + 1)'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        DB_REL
    } state_t;

    logic [3:0]     row_meta;
    logic [3:0]     row_sync;
    logic [SCW-1:0] scan_cnt;
    logic [1:0]     col;
    logic [15:0]    frame;
    logic           frame_done;
    logic           scan_last;

    logic [4:0]     bit_cnt;
    logic [3:0]     key_idx;
    logic           frame_none;
    logic           frame_single;

    state_t         state;
    state_t         state_next;
    logic [3:0]     cand;
    logic [3:0]     cand_next;
    logic [DBW-1:0] cnt;
    logic [DBW-1:0] cnt_next;
    logic [DBW:0]   cnt_inc;
    logic           report;
    logic           pressed_next;
    logic           ack_eff;

    assign scan_last = (scan_cnt == SCAN_LAST);
    assign cnt_inc   = {1'b0, cnt} + (DBW + 1)'(1);
    assign ack_eff   = keyAck && keyValid;

    // Two-flop synchronizer for the asynchronous row inputs (idle = high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= rowSense;
            row_sync <= row_meta;
        end
    end

    // Column dwell counter, column rotation and frame capture at terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt   <= '0;
            col        <= '0;
            frame      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= scan_last && (col == 2'd3);
            if (scan_last) begin
                scan_cnt                <= '0;
                col                     <= col + 2'd1;
                frame[{col, 2'b00} +: 4] <= ~row_sync;
            end else begin
                scan_cnt <= scan_cnt + SCW'(1);
            end
        end
    end

    // Active-low one-hot column drive decoded from the column index.
    always_comb begin
        colDrive = ~(4'b0001 << col);
    end

    // Classify the captured frame: number of closed keys and index of the last one.
    always_comb begin
        bit_cnt = '0;
        key_idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            bit_cnt = bit_cnt + 5'(frame[i]);
            if (frame[i]) begin
                key_idx = 4'(i);
            end
        end
        frame_none   = (bit_cnt == 5'd0);
        frame_single = (bit_cnt == 5'd1);
    end

    // FSM state register together with candidate key, frame counter and held level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cand       <= '0;
            cnt        <= '0;
            keyPressed <= 1'b0;
        end else begin
            state      <= state_next;
            cand       <= cand_next;
            cnt        <= cnt_next;
            keyPressed <= pressed_next;
        end
    end

    // Next-state logic, evaluated only on the cycle after a frame completes.
    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        if (frame_done) begin
            case (state)
                IDLE: begin
                    if (frame_single) begin
                        cand_next  = key_idx;
                        cnt_next   = DBW'(1);
                        state_next = (DEBOUNCE_SCANS == 1) ? PRESSED : DB_PRESS;
                    end
                end
                DB_PRESS: begin
                    if (frame_single && (key_idx == cand)) begin
                        cnt_next = cnt_inc[DBW-1:0];
                        if (cnt_inc >= DB_TGT) begin
                            state_next = PRESSED;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
                PRESSED: begin
                    if (!(frame_single && (key_idx == cand))) begin
                        cnt_next   = DBW'(1);
                        state_next = DB_REL;
                    end
                end
                DB_REL: begin
                    if (frame_none) begin
                        cnt_next = cnt_inc[DBW-1:0];
                        if (cnt_inc >= DB_TGT) begin
                            state_next = IDLE;
                        end
                    end else begin
                        state_next = PRESSED;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM outputs: a report fires on the transition into PRESSED from a press phase.
    always_comb begin
        report       = ((state == IDLE) || (state == DB_PRESS)) && (state_next == PRESSED);
        pressed_next = (state_next == PRESSED) || (state_next == DB_REL);
    end

    // Valid/ack handshake with sticky overrun; a same-cycle ack frees the slot for a new report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keyCode  <= '0;
            keyValid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (report) begin
                if (!keyValid || ack_eff) begin
                    keyCode  <= key_idx;
                    keyValid <= 1'b1;
                end
            end else if (ack_eff) begin
                keyValid <= 1'b0;
            end

            if (report && keyValid && !keyAck) begin
                overrun <= 1'b1;
            end else if (clrOverrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb_key_matrix_scanner: drives a modelled key matrix frame by frame (directed
// scenarios plus random segments) and compares every cycle against a
// frame-level reference model of the debounce and handshake rules.
module tb_key_matrix_scanner;

    localparam int SCAN  = 4;
    localparam int DB    = 2;
    localparam int FRAME = 4 * SCAN;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] colDrive;
    logic [3:0] rowSense;
    logic [3:0] keyCode;
    logic       keyValid;
    logic       keyAck = 1'b0;
    logic       keyPressed;
    logic       overrun;
    logic       clrOverrun = 1'b0;

    key_matrix_scanner #(
        .SCAN_COUNT     (SCAN),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .colDrive   (colDrive),
        .rowSense   (rowSense),
        .keyCode    (keyCode),
        .keyValid   (keyValid),
        .keyAck     (keyAck),
        .keyPressed (keyPressed),
        .overrun    (overrun),
        .clrOverrun (clrOverrun)
    );

    always #5 clk = ~clk;

    // Physical matrix: key (c,r) closed pulls row r low while column c is driven low.
    logic [15:0] keys = '0;
    always_comb begin
        rowSense = '1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!colDrive[c] && keys[c*4 + r]) rowSense[r] = 1'b0;
    end

    typedef struct {
        logic [15:0] mask;
        int          ack_rate;
        int          clr_rate;
    } seg_t;

    seg_t        plan[$];
    logic [15:0] applied_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int ack_rate = 0;
    int clr_rate = 0;

    // Reference model state
    int         m_held;
    int         m_streak;
    int         m_skey;
    int         m_quiet;
    logic       m_valid;
    logic [3:0] m_code;
    logic       m_ovr;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic add_frames(input logic [15:0] mask, input int count, input int ack, input int clr);
        seg_t s;
        s.mask = mask;
        s.ack_rate = ack;
        s.clr_rate = clr;
        for (int i = 0; i < count; i++) plan.push_back(s);
    endtask

    task automatic start_frame();
        seg_t s;
        if (plan.size() > 0) begin
            s = plan.pop_front();
        end else begin
            s.mask = '0;
            s.ack_rate = 0;
            s.clr_rate = 0;
        end
        keys     = s.mask;
        ack_rate = s.ack_rate;
        clr_rate = s.clr_rate;
        applied_q.push_back(s.mask);
    endtask

    task automatic model_reset();
        m_held   = -1;
        m_streak = 0;
        m_skey   = 0;
        m_quiet  = 0;
        m_valid  = 1'b0;
        m_code   = '0;
        m_ovr    = 1'b0;
    endtask

    // Frame-level debounce rules: a press needs DB consecutive frames showing only
    // that key; release needs DB frames starting at the first frame that is not the
    // held key alone, all later ones empty.
    task automatic model_frame(input logic [15:0] mask, output logic rep, output logic [3:0] code);
        int n_keys;
        int idx;
        n_keys = 0;
        idx = 0;
        rep = 1'b0;
        code = '0;
        for (int i = 0; i < 16; i++) begin
            if (mask[i]) begin
                n_keys++;
                idx = i;
            end
        end
        if (m_held < 0) begin
            if (n_keys == 1 && (m_streak == 0 || idx == m_skey)) begin
                m_streak++;
                m_skey = idx;
                if (m_streak >= DB) begin
                    rep = 1'b1;
                    code = 4'(idx);
                    m_held = idx;
                    m_streak = 0;
                    m_quiet = 0;
                end
            end else begin
                m_streak = 0;
            end
        end else if (m_quiet == 0) begin
            if (!(n_keys == 1 && idx == m_held)) m_quiet = 1;
        end else if (n_keys == 0) begin
            m_quiet++;
            if (m_quiet >= DB) begin
                m_held = -1;
                m_quiet = 0;
            end
        end else begin
            m_quiet = 0;
        end
    endtask

    task automatic step();
        logic       rep;
        logic [3:0] code;
        logic       v_old;
        logic       ack_eff;
        logic [3:0] exp_col;
        logic [15:0] m;
        @(posedge clk);
        #1;
        cyc++;
        rep = 1'b0;
        code = '0;
        if ((cyc % FRAME) == 1 && cyc > FRAME) begin
            if (applied_q.size() > 0) begin
                m = applied_q.pop_front();
                model_frame(m, rep, code);
            end
        end
        v_old = m_valid;
        ack_eff = keyAck && m_valid;
        if (rep) begin
            if (!m_valid || ack_eff) begin
                m_code = code;
                m_valid = 1'b1;
            end
        end else if (ack_eff) begin
            m_valid = 1'b0;
        end
        if (rep && v_old && !keyAck) m_ovr = 1'b1;
        else if (clrOverrun) m_ovr = 1'b0;

        exp_col = ~(4'b0001 << ((cyc / SCAN) % 4));
        check_eq("colDrive",   16'(colDrive),   16'(exp_col));
        check_eq("keyValid",   16'(keyValid),   16'(m_valid));
        check_eq("keyCode",    16'(keyCode),    16'(m_code));
        check_eq("keyPressed", 16'(keyPressed), 16'(m_held >= 0));
        check_eq("overrun",    16'(overrun),    16'(m_ovr));

        if ((cyc % FRAME) == 0) start_frame();
        keyAck     = ($urandom_range(0, 99) < ack_rate);
        clrOverrun = ($urandom_range(0, 99) < clr_rate);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        keyAck = 1'b0;
        clrOverrun = 1'b0;
        #1;
        check_eq("rst_colDrive",   16'(colDrive),   16'h000E);
        check_eq("rst_keyValid",   16'(keyValid),   16'h0000);
        check_eq("rst_keyCode",    16'(keyCode),    16'h0000);
        check_eq("rst_keyPressed", 16'(keyPressed), 16'h0000);
        check_eq("rst_overrun",    16'(overrun),    16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        model_reset();
        applied_q.delete();
        start_frame();
    endtask

    task automatic run_plan();
        int budget;
        budget = (plan.size() + 4) * FRAME;
        while (plan.size() > 0 && budget > 0) begin
            step();
            budget--;
        end
        if (plan.size() > 0) check_eq("plan_budget", 16'(plan.size()), 16'h0000);
        repeat (3 * FRAME) step();
    endtask

    initial begin
        int kind;
        int a;
        int b;
        int len;
        model_reset();

        // idle rows
        add_frames(16'h0000, 3, 0, 0);
        // key 9 held, acked, released: single report
        add_frames(16'h0001 << 9, 5, 0, 0);
        add_frames(16'h0001 << 9, 1, 100, 0);
        add_frames(16'h0000, 3, 0, 0);
        // one-frame blip on key 4
        add_frames(16'h0001 << 4, 1, 0, 0);
        add_frames(16'h0000, 3, 0, 0);
        // two keys together (keys 0 and 15)
        add_frames(16'h8001, 6, 0, 0);
        add_frames(16'h0000, 2, 0, 0);
        // unacked key 5, then key 6 overruns, clear, ack, key 6 again
        add_frames(16'h0001 << 5, 3, 0, 0);
        add_frames(16'h0000, 3, 0, 0);
        add_frames(16'h0001 << 6, 3, 0, 0);
        add_frames(16'h0000, 2, 0, 100);
        add_frames(16'h0000, 1, 100, 0);
        add_frames(16'h0001 << 6, 3, 0, 0);
        add_frames(16'h0000, 2, 100, 0);
        // random segments
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 3));
            a = int'($urandom_range(0, 15));
            b = (a + int'($urandom_range(1, 15))) % 16;
            case (kind)
                0: add_frames(16'h0000, int'($urandom_range(1, 3)), int'($urandom_range(0, 2)) * 40, 0);
                1: add_frames(16'h0001 << a, int'($urandom_range(1, 5)), int'($urandom_range(0, 2)) * 40,
                              int'($urandom_range(0, 1)) * 30);
                2: add_frames((16'h0001 << a) | (16'h0001 << b), int'($urandom_range(1, 2)), 0, 0);
                default: begin
                    len = int'($urandom_range(2, 4));
                    add_frames(16'h0001 << a, len, 0, 0);
                    add_frames(16'h0001 << b, len, int'($urandom_range(0, 1)) * 80, 0);
                end
            endcase
        end

        #2;
        do_reset();
        run_plan();

        // reset during press debounce with the key still held
        plan.delete();
        add_frames(16'h0001 << 12, 10, 0, 0);
        do_reset();
        repeat (24) step();
        check_eq("mid_db_keyValid", 16'(keyValid), 16'h0000);
        plan.delete();
        add_frames(16'h0001 << 12, 4, 0, 0);
        add_frames(16'h0000, 3, 100, 0);
        do_reset();
        run_plan();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
